// File: rtl/wakey_pkg.sv
// Shared definitions for the wake conditioning path: FSM state encoding and default tuning.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wakey_pkg;

    typedef enum logic [1:0] {
        WAKE_IDLE     = 2'd0,
        WAKE_HOLD     = 2'd1,
        WAKE_COOLDOWN = 2'd2
    } wake_state_t;

    // Default tuning, reused by the top-level instantiation of wake_ctrl.
    localparam int WAKE_WINDOW          = 4;
    localparam int WAKE_THRESH          = 3;
    localparam int WAKE_HOLD_CYCLES     = 16;
    localparam int WAKE_COOLDOWN_CYCLES = 16;
    localparam int WAKE_EVT_BW          = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wake_history.sv
// Decision history: WINDOW-bit shift register with a popcount of the value it would hold after the next shift.
// Latency: score is combinational from the current history and din; history updates on the clock edge.
// Backpressure: none; shift_en is a qualified strobe, clear/flush zero the history and win over a shift.
//   clk      in   1                  clock
//   rst_n    in   1                  synchronous active-low reset
//   clear    in   1                  zero history (soft clear)
//   flush    in   1                  zero history (detection accepted)
//   shift_en in   1                  shift din into history
//   din      in   1                  decision bit
//   score    out  clog2(WINDOW+1)    ones in the post-shift history
module wake_history #(
    parameter int WINDOW = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         flush,
    input  logic                         shift_en,
    input  logic                         din,
    output logic [$clog2(WINDOW+1)-1:0]  score
);
    localparam int SCORE_W = $clog2(WINDOW + 1);

    logic [WINDOW-1:0] hist;
    logic [WINDOW-1:0] hist_next;

    generate
        if (WINDOW == 1) begin : g_single
            assign hist_next = din;
        end else begin : g_multi
            assign hist_next = {hist[WINDOW-2:0], din};
        end
    endgenerate

    // Scoring the post-shift value lets the FSM decide in the same cycle as the strobe.
    always_comb begin
        score = '0;
        for (int i = 0; i < WINDOW; i++) begin
            score = score + SCORE_W'(hist_next[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (clear || flush) begin
            hist <= '0;
        end else if (shift_en) begin
            hist <= hist_next;
        end
    end

endmodule

// File: rtl/wake_ctrl.sv
// Wake pin conditioner: M-of-K vote on WRD decisions, fixed-width wake pulse, then cooldown.
// Latency: wake_o rises one clk after the qualifying wake_valid_i cycle.
// Backpressure: none; decisions arriving while busy_o is high are dropped.
//   clk_i        in   1       clock
//   rst_n_i      in   1       synchronous active-low reset
//   wake_i       in   1       decision, valid with wake_valid_i
//   wake_valid_i in   1       decision strobe
//   clear_i      in   1       soft clear (keeps evt_cnt_o)
//   wake_o       out  1       registered wake pin
//   busy_o       out  1       high in HOLD or COOLDOWN
//   evt_cnt_o    out  EVT_BW  saturating wake event count
module wake_ctrl
    import wakey_pkg::*;
#(
    parameter int WINDOW          = WAKE_WINDOW,
    parameter int THRESH          = WAKE_THRESH,
    parameter int HOLD_CYCLES     = WAKE_HOLD_CYCLES,
    parameter int COOLDOWN_CYCLES = WAKE_COOLDOWN_CYCLES,
    parameter int EVT_BW          = WAKE_EVT_BW
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wake_i,
    input  logic              wake_valid_i,
    input  logic              clear_i,
    output logic              wake_o,
    output logic              busy_o,
    output logic [EVT_BW-1:0] evt_cnt_o
);
    localparam int SCORE_W = $clog2(WINDOW + 1);
    localparam int CNT_W   = $clog2(max_int(HOLD_CYCLES, COOLDOWN_CYCLES) + 1);

    localparam logic [SCORE_W-1:0] THRESH_V  = SCORE_W'(THRESH);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   COOL_LAST = CNT_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

    wake_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [SCORE_W-1:0] score;
    logic               accept;
    logic               fire;

    // Only decisions seen in IDLE enter the history; clear wins over a same-cycle strobe.
    assign accept = (state == WAKE_IDLE) && wake_valid_i && !clear_i;
    assign fire   = accept && (score >= THRESH_V);

    wake_history #(
        .WINDOW (WINDOW)
    ) u_history (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .clear    (clear_i),
        .flush    (fire),
        .shift_en (accept),
        .din      (wake_i),
        .score    (score)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state     <= WAKE_IDLE;
            cnt       <= '0;
            wake_o    <= 1'b0;
            busy_o    <= 1'b0;
            evt_cnt_o <= '0;
        end else if (clear_i) begin
            state  <= WAKE_IDLE;
            cnt    <= '0;
            wake_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            case (state)
                WAKE_IDLE: begin
                    if (fire) begin
                        state  <= WAKE_HOLD;
                        cnt    <= '0;
                        wake_o <= 1'b1;
                        busy_o <= 1'b1;
                        if (evt_cnt_o != '1) begin
                            evt_cnt_o <= evt_cnt_o + 1'b1;
                        end
                    end
                end
                WAKE_HOLD: begin
                    // cnt runs 0..HOLD_CYCLES-1, one value per cycle wake_o is high.
                    if (cnt == HOLD_LAST) begin
                        cnt    <= '0;
                        wake_o <= 1'b0;
                        if (COOLDOWN_CYCLES == 0) begin
                            state  <= WAKE_IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= WAKE_COOLDOWN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAKE_COOLDOWN: begin
                    if (cnt == COOL_LAST) begin
                        state  <= WAKE_IDLE;
                        busy_o <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= WAKE_IDLE;
                    cnt    <= '0;
                    wake_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wake_ctrl.sv
// Bench for wake_ctrl: directed table, hand-written corner sequences and randomized traffic vs a queue-based model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_wake_ctrl;
    localparam int WINDOW  = 4;
    localparam int THRESH  = 3;
    localparam int HOLD    = 8;
    localparam int COOL    = 4;
    localparam int EVT_BW  = 2;
    localparam int EVT_MAX = (1 << EVT_BW) - 1;

    logic              clk;
    logic              rst_n;
    logic              wk;
    logic              wv;
    logic              clr;
    logic              wake;
    logic              busy;
    logic [EVT_BW-1:0] evt;

    int checks;
    int errors;

    // Reference model: last accepted decisions, busy cycles remaining, event count.
    int q[$];
    int rem;
    int m_evt;

    wake_ctrl #(
        .WINDOW          (WINDOW),
        .THRESH          (THRESH),
        .HOLD_CYCLES     (HOLD),
        .COOLDOWN_CYCLES (COOL),
        .EVT_BW          (EVT_BW)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .wake_i       (wk),
        .wake_valid_i (wv),
        .clear_i      (clr),
        .wake_o       (wake),
        .busy_o       (busy),
        .evt_cnt_o    (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic c;
        logic v;
        logic w;
        logic ew;
        logic eb;
        int   ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic c, input logic v, input logic w,
                       input logic ew, input logic eb, input int ee);
        vec_t t;
        t.r = r; t.c = c; t.v = v; t.w = w; t.ew = ew; t.eb = eb; t.ee = ee;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic c, input logic v, input logic w);
        int ones;
        if (!r) begin
            q.delete();
            rem   = 0;
            m_evt = 0;
        end else if (c) begin
            q.delete();
            rem = 0;
        end else if (rem > 0) begin
            rem--;
        end else if (v) begin
            q.push_back(w ? 1 : 0);
            if (q.size() > WINDOW) void'(q.pop_front());
            ones = 0;
            foreach (q[i]) ones += q[i];
            if (ones >= THRESH) begin
                q.delete();
                rem = HOLD + COOL;
                if (m_evt < EVT_MAX) m_evt++;
            end
        end
    endtask

    // One clock: drive, advance, update model, compare all outputs to the model.
    task automatic step(input logic r, input logic c, input logic v, input logic w);
        rst_n = r; clr = c; wv = v; wk = w;
        @(posedge clk);
        #1;
        model(r, c, v, w);
        chk("model_wake", int'(wake), (rem > COOL) ? 1 : 0);
        chk("model_busy", int'(busy), (rem > 0) ? 1 : 0);
        chk("model_evt", int'(evt), m_evt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fire3();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rem    = 0;
        m_evt  = 0;
        rst_n  = 1'b0;
        clr    = 1'b0;
        wv     = 1'b0;
        wk     = 1'b0;

        // Reset, then decisions 1,1,0,1: fires after 4th strobe, 8 high, 12 busy.
        add(0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 1, 1, 1, 1);
        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1);
        // Decisions 1,0,0,1,0,1: never three ones in the window.
        add(1, 0, 1, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 0, 1);
        add(1, 0, 1, 1, 0, 0, 1);

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].c, tbl[k].v, tbl[k].w);
            chk("tbl_wake", int'(wake), int'(tbl[k].ew));
            chk("tbl_busy", int'(busy), int'(tbl[k].eb));
            chk("tbl_evt", int'(evt), tbl[k].ee);
        end

        // Strobes of 1 every cycle through HOLD/COOLDOWN are dropped; refire on 3rd post-IDLE strobe.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("seq_no_early_fire", int'(wake), 0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("seq_fire", int'(wake), 1);
        chk("seq_evt2", int'(evt), 2);
        for (int i = 1; i <= 15; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            chk("seq_ign_wake", int'(wake), (i <= 7 || i == 15) ? 1 : 0);
            chk("seq_ign_busy", int'(busy), (i <= 11 || i == 15) ? 1 : 0);
        end
        chk("seq_evt3", int'(evt), 3);
        idle(12);

        // Clear on cycle 3 of HOLD keeps the event count.
        fire3();
        idle(2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("clr_wake", int'(wake), 0);
        chk("clr_busy", int'(busy), 0);
        chk("clr_evt_kept", int'(evt), 3);

        // Clear beats a simultaneous strobe and wipes the history.
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_prio_wake", int'(wake), 0);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("clr_hist_wake", int'(wake), 0);
        idle(1);

        // Reset on cycle 3 of HOLD zeroes the event count.
        fire3();
        idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_wake", int'(wake), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_evt", int'(evt), 0);
        idle(1);

        // Five events with a 2-bit counter: sticks at 3.
        for (int e = 1; e <= 5; e++) begin
            fire3();
            chk("sat_wake", int'(wake), 1);
            chk("sat_evt", int'(evt), (e < 3) ? e : 3);
            idle(12);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            step(logic'($urandom_range(0, 299) != 0),
                 logic'($urandom_range(0, 99) == 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 2) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
